// File: rtl/svc_rv_sram_arb_pkg.sv
// Shared types for the I/D single-port SRAM arbiter.
//   arb_port_t     : identifies the fetch (I) or data (D) requester
//   CONFLICT_CNT_W : width of the saturating conflict-cycle counter
package svc_rv_sram_arb_pkg;

  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_port_t;

  localparam int unsigned CONFLICT_CNT_W = 32;

endpackage : svc_rv_sram_arb_pkg

// File: rtl/svc_rv_sram_arb_rr2.sv
// Two-way round-robin grant with a last-grant register.
//   clk, rst  : clock, synchronous active-high reset
//   req_i_i   : request from the I port
//   req_d_i   : request from the D port
//   gnt_i_o   : I granted this cycle (combinational)
//   gnt_d_o   : D granted this cycle (combinational)
// A grant is always a transfer, because it is only given to a valid requester.
// No grant is issued while rst is high.
module svc_rv_sram_arb_rr2
  import svc_rv_sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_i_i,
  input  logic req_d_i,
  output logic gnt_i_o,
  output logic gnt_d_o
);

  arb_port_t last_q;

  always_comb begin
    gnt_i_o = 1'b0;
    gnt_d_o = 1'b0;
    if (!rst) begin
      if (req_i_i && req_d_i) begin
        // On conflict, the port that did not win last time is served.
        gnt_d_o = (last_q == ARB_I);
        gnt_i_o = (last_q == ARB_D);
      end else begin
        gnt_i_o = req_i_i;
        gnt_d_o = req_d_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= ARB_I;
    end else if (gnt_i_o) begin
      last_q <= ARB_I;
    end else if (gnt_d_o) begin
      last_q <= ARB_D;
    end
  end

endmodule : svc_rv_sram_arb_rr2

// File: rtl/svc_rv_sram_arb.sv
// Shares one single-port synchronous SRAM between the instruction-fetch (I)
// and data (D) ports of the core. One access per cycle, round-robin on
// conflict, 1-cycle read responses routed back to their owner.
//   i_req_*      : fetch request (read only), ready = accepted this cycle
//   i_rd_*       : fetch response, data held until the next fetch response
//   d_req_*      : data request (read or byte-strobed write)
//   d_rd_*       : data read response, data held until the next one
//   sram_*       : SRAM port, driven combinationally from the granted request
//   conflict_cnt : saturating count of cycles with both requests valid
module svc_rv_sram_arb
  import svc_rv_sram_arb_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_valid,
  output logic                      i_req_ready,
  input  logic [AW-1:0]             i_req_addr,
  output logic                      i_rd_valid,
  output logic [DW-1:0]             i_rd_data,
  input  logic                      d_req_valid,
  output logic                      d_req_ready,
  input  logic [AW-1:0]             d_req_addr,
  input  logic                      d_req_we,
  input  logic [DW-1:0]             d_req_wdata,
  input  logic [DW/8-1:0]           d_req_wstrb,
  output logic                      d_rd_valid,
  output logic [DW-1:0]             d_rd_data,
  output logic                      sram_en,
  output logic                      sram_we,
  output logic [AW-1:0]             sram_addr,
  output logic [DW-1:0]             sram_wdata,
  output logic [DW/8-1:0]           sram_wstrb,
  input  logic [DW-1:0]             sram_rdata,
  output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

  logic                      gnt_i;
  logic                      gnt_d;
  logic                      rd_xfer;
  logic                      rsp_pend_q, rsp_pend_d;
  arb_port_t                 rsp_own_q, rsp_own_d;
  logic [DW-1:0]             i_rd_data_q;
  logic [DW-1:0]             d_rd_data_q;
  logic [CONFLICT_CNT_W-1:0] cnt_q;

  svc_rv_sram_arb_rr2 u_rr2 (
    .clk     (clk),
    .rst     (rst),
    .req_i_i (i_req_valid),
    .req_d_i (d_req_valid),
    .gnt_i_o (gnt_i),
    .gnt_d_o (gnt_d)
  );

  always_comb begin
    i_req_ready = gnt_i;
    d_req_ready = gnt_d;
    sram_en     = gnt_i | gnt_d;
    sram_we     = gnt_d & d_req_we;
    sram_addr   = '0;
    sram_wdata  = '0;
    sram_wstrb  = '0;
    if (gnt_d) begin
      sram_addr  = d_req_addr;
      sram_wdata = d_req_wdata;
      if (d_req_we) begin
        sram_wstrb = d_req_wstrb;
      end
    end else if (gnt_i) begin
      sram_addr = i_req_addr;
    end
  end

  always_comb begin
    rd_xfer    = gnt_i | (gnt_d & ~d_req_we);
    rsp_pend_d = rd_xfer;
    rsp_own_d  = ARB_I;
    if (rd_xfer && gnt_d) begin
      rsp_own_d = ARB_D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q <= 1'b0;
      rsp_own_q  <= ARB_I;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_own_q  <= rsp_own_d;
    end
  end

  // The SRAM word is only present in the response cycle, so rd_data shows it
  // directly while rd_valid is high and the register keeps it afterwards.
  // A response still pending when rst rises is suppressed.
  always_comb begin
    i_rd_valid = rsp_pend_q & (rsp_own_q == ARB_I) & ~rst;
    d_rd_valid = rsp_pend_q & (rsp_own_q == ARB_D) & ~rst;
    i_rd_data  = i_rd_valid ? sram_rdata : i_rd_data_q;
    d_rd_data  = d_rd_valid ? sram_rdata : d_rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_rd_data_q <= '0;
      d_rd_data_q <= '0;
    end else begin
      if (i_rd_valid) begin
        i_rd_data_q <= sram_rdata;
      end
      if (d_rd_valid) begin
        d_rd_data_q <= sram_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (i_req_valid && d_req_valid && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CONFLICT_CNT_W'(1);
    end
  end

  assign conflict_cnt = cnt_q;

endmodule : svc_rv_sram_arb

// File: tb/tb_svc_rv_sram_arb.sv
// Directed and randomised checks of svc_rv_sram_arb against a behavioural
// SRAM and a bench-side reference memory.
module tb_svc_rv_sram_arb;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          i_req_valid, i_req_ready;
  logic [AW-1:0] i_req_addr;
  logic          i_rd_valid;
  logic [DW-1:0] i_rd_data;
  logic          d_req_valid, d_req_ready;
  logic [AW-1:0] d_req_addr;
  logic          d_req_we;
  logic [DW-1:0] d_req_wdata;
  logic [3:0]    d_req_wstrb;
  logic          d_rd_valid;
  logic [DW-1:0] d_rd_data;
  logic          sram_en, sram_we;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata;
  logic [3:0]    sram_wstrb;
  logic [DW-1:0] sram_rdata;
  logic [31:0]   conflict_cnt;

  int checks   = 0;
  int failures = 0;

  logic [31:0] sram_mem [0:1023];
  logic [31:0] ref_mem  [0:1023];

  svc_rv_sram_arb #(.AW(AW), .DW(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (i_req_valid),
    .i_req_ready  (i_req_ready),
    .i_req_addr   (i_req_addr),
    .i_rd_valid   (i_rd_valid),
    .i_rd_data    (i_rd_data),
    .d_req_valid  (d_req_valid),
    .d_req_ready  (d_req_ready),
    .d_req_addr   (d_req_addr),
    .d_req_we     (d_req_we),
    .d_req_wdata  (d_req_wdata),
    .d_req_wstrb  (d_req_wstrb),
    .d_rd_valid   (d_rd_valid),
    .d_rd_data    (d_rd_data),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_wstrb   (sram_wstrb),
    .sram_rdata   (sram_rdata),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] ws);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (ws[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  // Behavioural single-port SRAM: write at the edge, read data next cycle.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_wstrb);
      else         sram_rdata <= sram_mem[sram_addr];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    i_req_valid = 1'b0; i_req_addr = '0;
    d_req_valid = 1'b0; d_req_addr = '0; d_req_we = 1'b0;
    d_req_wdata = '0;   d_req_wstrb = '0;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_fetch [0:2];
  logic        i_pend, d_pend, i_wait, d_wait;
  logic        exp_iv, exp_dv;
  logic [31:0] exp_id, exp_dd, last_id, last_dd;
  int          conf;

  initial begin
    exp_fetch[0] = 32'h0000_0013;
    exp_fetch[1] = 32'h0010_0093;
    exp_fetch[2] = 32'h0020_0113;
    for (int a = 0; a < 1024; a++) sram_mem[a] = 32'h0;
    sram_mem[0]      = 32'h0000_0013;
    sram_mem[1]      = 32'h0010_0093;
    sram_mem[2]      = 32'h0020_0113;
    sram_mem[10'h010] = 32'hA5A5_0010;
    sram_mem[10'h120] = 32'h1122_3344;
    sram_mem[10'h200] = 32'h5A5A_0200;
    sram_rdata = '0;

    // Reset: a request presented during rst is not granted.
    rst = 1'b1;
    idle();
    i_req_valid = 1'b1;
    @(negedge clk); #1;
    chk("rst_i_ready", i_req_ready, 0);
    chk("rst_sram_en", sram_en, 0);
    after_edge();
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    chk("rv_i_rd_valid", i_rd_valid, 0);
    chk("rv_d_rd_valid", d_rd_valid, 0);
    chk("rv_i_rd_data", i_rd_data, 0);
    chk("rv_d_rd_data", d_rd_data, 0);
    chk("rv_conflict", conflict_cnt, 0);
    chk("rv_sram_en", sram_en, 0);
    chk("rv_i_ready", i_req_ready, 0);

    // Back-to-back fetches.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = AW'(k);
      #1;
      chk("f_i_ready", i_req_ready, 1);
      chk("f_sram_addr", sram_addr, k);
      chk("f_sram_we", sram_we, 0);
      after_edge();
      chk("f_i_rd_valid", i_rd_valid, 1);
      chk("f_i_rd_data", i_rd_data, exp_fetch[k]);
      chk("f_d_rd_valid", d_rd_valid, 0);
    end
    @(negedge clk); idle();
    after_edge();
    chk("f_idle_valid", i_rd_valid, 0);
    chk("f_hold_data", i_rd_data, 32'h0020_0113);

    // D full write then read.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h100;
    d_req_wdata = 32'hDEAD_BEEF; d_req_wstrb = 4'hF;
    #1;
    chk("w_d_ready", d_req_ready, 1);
    chk("w_sram_we", sram_we, 1);
    chk("w_sram_wstrb", sram_wstrb, 4'hF);
    chk("w_sram_wdata", sram_wdata, 32'hDEAD_BEEF);
    after_edge();
    chk("w_no_rsp", d_rd_valid, 0);
    @(negedge clk);
    d_req_we = 1'b0;
    #1;
    chk("r_sram_we", sram_we, 0);
    chk("r_sram_wstrb", sram_wstrb, 0);
    after_edge();
    chk("r_d_rd_valid", d_rd_valid, 1);
    chk("r_d_rd_data", d_rd_data, 32'hDEAD_BEEF);
    chk("r_i_rd_valid", i_rd_valid, 0);

    // Four conflict cycles right after reset: D, I, D, I.
    @(negedge clk); idle(); rst = 1'b1;
    after_edge();
    @(negedge clk); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      i_req_valid = 1'b1; i_req_addr = 10'h010;
      d_req_valid = 1'b1; d_req_addr = 10'h200; d_req_we = 1'b0;
      #1;
      chk("c_d_ready", d_req_ready, (k % 2 == 0));
      chk("c_i_ready", i_req_ready, (k % 2 == 1));
      after_edge();
      if (k % 2 == 0) begin
        chk("c_d_rd_valid", d_rd_valid, 1);
        chk("c_d_rd_data", d_rd_data, 32'h5A5A_0200);
        chk("c_i_rd_valid", i_rd_valid, 0);
      end else begin
        chk("c_i_rd_valid", i_rd_valid, 1);
        chk("c_i_rd_data", i_rd_data, 32'hA5A5_0010);
        chk("c_d_rd_valid", d_rd_valid, 0);
        chk("c_d_hold", d_rd_data, 32'h5A5A_0200);
      end
    end
    @(negedge clk); idle();
    #1;
    chk("c_conflict_cnt", conflict_cnt, 4);

    // Byte-strobed write merges into the existing word.
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = 10'h120;
    d_req_wdata = 32'h0000_AB00; d_req_wstrb = 4'b0010;
    after_edge();
    @(negedge clk); idle();
    @(negedge clk);
    d_req_valid = 1'b1; d_req_addr = 10'h120;
    after_edge();
    chk("p_d_rd_valid", d_rd_valid, 1);
    chk("p_d_rd_data", d_rd_data, 32'h1122_AB44);

    // Reset the cycle after an accepted fetch drops its response.
    @(negedge clk); idle();
    i_req_valid = 1'b1; i_req_addr = 10'h001;
    #1;
    chk("m_i_ready", i_req_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    i_req_addr = 10'h002;
    #1;
    chk("m_rst_ready", i_req_ready, 0);
    after_edge();
    chk("m_i_rd_valid", i_rd_valid, 0);
    chk("m_i_rd_data", i_rd_data, 0);
    chk("m_d_rd_data", d_rd_data, 0);
    chk("m_conflict", conflict_cnt, 0);
    @(negedge clk); rst = 1'b0; idle();
    after_edge();
    chk("m_post_i_rd_valid", i_rd_valid, 0);

    // Randomised traffic against the reference memory.
    for (int a = 0; a < 1024; a++) ref_mem[a] = sram_mem[a];
    i_pend = 1'b0; d_pend = 1'b0; i_wait = 1'b0; d_wait = 1'b0;
    last_id = 32'h0; last_dd = 32'h0; conf = 0;
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      if (i_pend) begin
        if ($urandom_range(0, 7) == 0) i_req_valid = 1'b0;
      end else begin
        i_req_valid = ($urandom_range(0, 3) != 0);
        i_req_addr  = AW'($urandom_range(0, 15));
      end
      if (d_pend) begin
        if ($urandom_range(0, 7) == 0) d_req_valid = 1'b0;
      end else begin
        d_req_valid = ($urandom_range(0, 3) != 0);
        d_req_addr  = AW'($urandom_range(0, 15));
        d_req_we    = $urandom_range(0, 1) == 1;
        d_req_wdata = $urandom;
        d_req_wstrb = 4'($urandom_range(0, 15));
      end
      #1;
      if (i_req_valid && d_req_valid) conf++;
      chk("x_excl", {i_req_ready, d_req_ready} == 2'b11, 0);
      if (i_req_valid && !d_req_valid) chk("x_i_only", i_req_ready, 1);
      if (d_req_valid && !i_req_valid) chk("x_d_only", d_req_ready, 1);
      if (!i_req_valid) chk("x_i_novalid", i_req_ready, 0);
      if (!d_req_valid) chk("x_d_novalid", d_req_ready, 0);
      if (i_req_valid && i_wait) chk("x_i_starve", i_req_ready, 1);
      if (d_req_valid && d_wait) chk("x_d_starve", d_req_ready, 1);
      i_wait = i_req_valid && !i_req_ready;
      d_wait = d_req_valid && !d_req_ready;
      i_pend = i_wait;
      d_pend = d_wait;
      exp_iv = i_req_ready;
      exp_id = ref_mem[i_req_addr];
      exp_dv = d_req_ready && !d_req_we;
      exp_dd = ref_mem[d_req_addr];
      if (d_req_ready && d_req_we)
        ref_mem[d_req_addr] = merge(ref_mem[d_req_addr], d_req_wdata, d_req_wstrb);
      after_edge();
      chk("x_i_rd_valid", i_rd_valid, exp_iv);
      chk("x_d_rd_valid", d_rd_valid, exp_dv);
      if (exp_iv) last_id = exp_id;
      if (exp_dv) last_dd = exp_dd;
      chk("x_i_rd_data", i_rd_data, last_id);
      chk("x_d_rd_data", d_rd_data, last_dd);
    end
    @(negedge clk); idle();
    #1;
    chk("x_conflict_cnt", conflict_cnt, conf);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_svc_rv_sram_arb

// File: doc/svc_rv_sram_arb.md
Name: svc_rv_sram_arb

Overview:
Two-requester arbiter that shares one single-port synchronous SRAM between the RISC-V core's instruction-fetch port and its data port, forming a unified-memory SoC variant.
- Grants at most one access per cycle.
- Round-robin on conflict.
- Routes the 1-cycle-latency read data back to its owner.
- Counts conflict cycles for performance analysis.

Parameters:
AW, 10, SRAM word-address width
DW, 32, data width; must be a multiple of 8

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_req_valid  in  1  fetch request valid (read only)
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  AW  fetch word address
i_rd_valid  out  1  fetch read data valid (1-cycle pulse)
i_rd_data  out  DW  fetch read data, held until the next fetch response
d_req_valid  in  1  data request valid
d_req_ready  out  1  data request accepted this cycle
d_req_addr  in  AW  data word address
d_req_we  in  1  1 = write, 0 = read
d_req_wdata  in  DW  write data
d_req_wstrb  in  DW/8  byte write strobes
d_rd_valid  out  1  data read data valid (1-cycle pulse)
d_rd_data  out  DW  data read data, held until the next data read response
sram_en  out  1  SRAM access enable
sram_we  out  1  SRAM write enable
sram_addr  out  AW  SRAM address
sram_wdata  out  DW  SRAM write data
sram_wstrb  out  DW/8  SRAM byte strobes
sram_rdata  in  DW  SRAM read data, valid the cycle after sram_en && !sram_we
conflict_cnt  out  32  cycles with i_req_valid && d_req_valid both high; saturates at 2^32-1

Behaviour:
- Only clk is used; rst is sampled at posedge clk.
- A transfer occurs on valid && ready.
- Requester obligations: hold addr, we, wdata and wstrb stable while valid && !ready. A requester may drop valid without being granted.
- Grant logic is combinational from the valid inputs and the last_grant register:
  - Only one requester valid: that requester is granted.
  - Both valid: grant the port not equal to last_grant.
  - Neither valid: no grant, sram_en = 0.
- The ready of the non-granted port is 0.
- last_grant updates to the granted port on every transfer and is unchanged otherwise. Reset value is I, so D wins the first conflict.
- SRAM drive is combinational, mirroring the granted request:
  - sram_en = any transfer.
  - sram_we = d_req_we when D is granted, 0 when I is granted.
  - sram_wstrb = 0 for reads.
  - sram_addr and sram_wdata are muxed from the granted port.
- Response tracking uses registers rsp_pend (1 bit) and rsp_own (I/D):
  - rsp_pend is set on any read transfer; rsp_own records its owner.
  - Both are cleared when the next cycle has no read transfer.
- Read response:
  - The cycle after a read transfer, the owner's rd_valid = 1.
  - The owner's rd_data register loads sram_rdata on that edge.
  - Latency: request accepted at cycle N, data on rd_data with rd_valid at cycle N+1.
- Writes produce no response.
- Back-to-back reads from alternating ports are fully pipelined: one transfer per cycle, no bubbles.
- Responses have no backpressure; requesters must accept rd_valid.
- Read-after-write to the same address in consecutive cycles returns the new data, as provided by the SRAM's write-then-read ordering across cycles.
- conflict_cnt increments on every conflict cycle, including cycles where a grant occurs, and saturates at 2^32-1.
- Reset values: last_grant = I, rsp_pend = 0, i_rd_valid = d_rd_valid = 0, i_rd_data = d_rd_data = 0, conflict_cnt = 0.
  - Combinational outputs are 0 while all valids are 0.
  - During rst, ready is forced to 0.
- Reset mid-operation: a pending read response is dropped, with no rd_valid after the reset edge. Requests presented during rst are not granted.
- Stated edge cases:
  - A requester that drops valid while a conflict is lost causes no state change.
  - Simultaneous D write and I read on a conflict follow the round-robin rule.

Decomposition:
- Package svc_rv_sram_arb_pkg: typedef enum logic {ARB_I, ARB_D} arb_port_t; localparam conflict counter width 32.
- Sub-module svc_rv_sram_arb_rr2: 2-way round-robin grant with a last_grant register, reused for the I/D grant.
- Response routing and the counter stay in the top level.

Test Plan:
- Reset, then I-only reads at addrs 0x000, 0x001, 0x002 on consecutive cycles -> i_req_ready=1 each cycle; i_rd_valid at N+1 with the preloaded words 0x00000013, 0x00100093, 0x00200113; d_rd_valid stays 0.
- D write 0xDEADBEEF, wstrb=4'hF to addr 0x100, then D read of 0x100 -> d_rd_valid one cycle after the read with 0xDEADBEEF; no response for the write.
- Both valid for 4 cycles (I addr 0x010, D read addr 0x200) right after reset -> grants D, I, D, I; each response routed to the correct port; conflict_cnt = 4.
- D write wstrb=4'b0010, wdata=0x0000AB00 to a word holding 0x11223344 -> a later read returns 0x1122AB44.
- Reset asserted the cycle after an I read is accepted -> no i_rd_valid; outputs at reset values; conflict_cnt = 0.
- Random valids on both ports for 10k cycles against a reference memory model -> every read matches the model, no grant starvation beyond 1 cycle, and conflict_cnt equals the number of conflict cycles.
